// File: rtl/lap_timer_pkg.sv
// Shared definitions for the lap timer: FSM state encoding, BCD digit width
// and the per-field modulus (most significant field counts to 99, the rest
// to 59).
package lap_timer_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJUST = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    function automatic int field_mod(input int idx, input int num_fields);
        return (idx == num_fields - 1) ? 100 : 60;
    endfunction

endpackage

// File: rtl/bcd_field_counter.sv
// One two-digit BCD field counting modulo MOD.
//   clk_i, rst_ni      clock, async active-low reset
//   inc_i / dec_i      step request (up / down)
//   carry_in_i         enables an up step; borrow_in_i enables a down step
//   load_i, load_val_i parallel load, highest priority
//   value_o            current {tens, ones}
//   value_next_o       value after this cycle's edge
//   carry_out_o        carry_in_i while field sits at MOD-1
//   borrow_out_o       borrow_in_i while field sits at 0
module bcd_field_counter
    import lap_timer_pkg::*;
#(
    parameter int MOD = 60
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 inc_i,
    input  logic                 dec_i,
    input  logic                 carry_in_i,
    input  logic                 borrow_in_i,
    input  logic                 load_i,
    input  logic [2*BCD_W-1:0]   load_val_i,
    output logic [2*BCD_W-1:0]   value_o,
    output logic [2*BCD_W-1:0]   value_next_o,
    output logic                 carry_out_o,
    output logic                 borrow_out_o
);

    localparam logic [BCD_W-1:0] MAX_T = BCD_W'((MOD - 1) / 10);
    localparam logic [BCD_W-1:0] MAX_O = BCD_W'((MOD - 1) % 10);

    logic [BCD_W-1:0] ones_q, ones_d;
    logic [BCD_W-1:0] tens_q, tens_d;
    logic             at_max, at_zero;

    assign at_max  = (tens_q == MAX_T) && (ones_q == MAX_O);
    assign at_zero = (tens_q == '0) && (ones_q == '0);

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (load_i) begin
            {tens_d, ones_d} = load_val_i;
        end else if (inc_i && carry_in_i) begin
            if (at_max) begin
                ones_d = '0;
                tens_d = '0;
            end else if (ones_q == 4'd9) begin
                ones_d = '0;
                tens_d = tens_q + 1'b1;
            end else begin
                ones_d = ones_q + 1'b1;
            end
        end else if (dec_i && borrow_in_i) begin
            if (at_zero) begin
                ones_d = MAX_O;
                tens_d = MAX_T;
            end else if (ones_q == '0) begin
                ones_d = 4'd9;
                tens_d = tens_q - 1'b1;
            end else begin
                ones_d = ones_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ones_q <= '0;
            tens_q <= '0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
        end
    end

    assign value_o      = {tens_q, ones_q};
    assign value_next_o = {tens_d, ones_d};
    assign carry_out_o  = carry_in_i & at_max;
    assign borrow_out_o = borrow_in_i & at_zero;

endmodule

// File: rtl/lap_timer.sv
// Stopwatch / countdown with lap freeze and per-field adjust.
//   MegaClk, reset     clock, async active-low reset
//   tick_1hz           count strobe (RUN only)
//   tick_adj           adjust strobe (ADJUST only)
//   tick_blink         blink phase, 0 blanks unselected fields in ADJUST
//   pause_btn, lap_btn debounced levels, rising edge = command
//   adj, sel, dir      adjust mode level, adjust field, 0 up / 1 down
//   digits_o, blank_o  registered display digits and blank mask
//   running_o, lap_active_o, expired_o  status
//
// state   | meaning
// RUN     | counting on tick_1hz
// PAUSED  | count frozen, waiting for pause edge
// ADJUST  | tick_adj edits the selected field, no carry
// DONE    | terminal count reached, waiting for pause edge
module lap_timer
    import lap_timer_pkg::*;
#(
    parameter int NUM_FIELDS = 2,
    parameter int WRAP       = 1
) (
    input  logic                          MegaClk,
    input  logic                          reset,
    input  logic                          tick_1hz,
    input  logic                          tick_adj,
    input  logic                          tick_blink,
    input  logic                          pause_btn,
    input  logic                          lap_btn,
    input  logic                          adj,
    input  logic [$clog2(NUM_FIELDS)-1:0] sel,
    input  logic                          dir,
    output logic [8*NUM_FIELDS-1:0]       digits_o,
    output logic [2*NUM_FIELDS-1:0]       blank_o,
    output logic                          running_o,
    output logic                          lap_active_o,
    output logic                          expired_o
);

    localparam int SEL_W = $clog2(NUM_FIELDS);
    localparam int DW    = 2 * BCD_W * NUM_FIELDS;

    state_e                   state_q, state_d;
    logic                     pause_prev_q, lap_prev_q, adj_prev_q;
    logic                     lap_q, lap_d;
    logic                     expired_q, expired_d;
    logic [DW-1:0]            snap_q, snap_d;
    logic [DW-1:0]            digits_q, digits_d;
    logic [2*NUM_FIELDS-1:0]  blank_q, blank_d;
    logic [DW-1:0]            live_q, live_d;
    logic                     pause_edge, lap_edge, adj_fall;
    logic                     count_en, adj_step, inc_all, dec_all;
    logic                     all_max, all_zero;

    assign pause_edge = pause_btn & ~pause_prev_q;
    assign lap_edge   = lap_btn & ~lap_prev_q;
    assign adj_fall   = adj_prev_q & ~adj;

    // adj has priority over a simultaneous count tick
    assign count_en = (state_q == ST_RUN) & tick_1hz & ~adj;
    assign adj_step = (state_q == ST_ADJUST) & tick_adj;

    // Saturation (WRAP=0 at max) and the down-count floor suppress the step
    // entirely so no field moves.
    assign inc_all = (count_en & ~dir & ~(all_max & (WRAP == 0))) | (adj_step & ~dir);
    assign dec_all = (count_en & dir & ~all_zero) | (adj_step & dir);

    for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
        logic chain_c, chain_b, cin, bin, cout, bout, sel_hit;

        if (gi == 0) begin : g_lsb
            assign chain_c = 1'b1;
            assign chain_b = 1'b1;
        end else begin : g_upper
            assign chain_c = g_field[gi-1].cout;
            assign chain_b = g_field[gi-1].bout;
        end

        // In adjust the chain is cut: only the selected field is enabled.
        assign sel_hit = (sel == SEL_W'(gi));
        assign cin     = adj_step ? sel_hit : chain_c;
        assign bin     = adj_step ? sel_hit : chain_b;

        bcd_field_counter #(
            .MOD(field_mod(gi, NUM_FIELDS))
        ) u_field (
            .clk_i        (MegaClk),
            .rst_ni       (reset),
            .inc_i        (inc_all),
            .dec_i        (dec_all),
            .carry_in_i   (cin),
            .borrow_in_i  (bin),
            .load_i       (1'b0),
            .load_val_i   ('0),
            .value_o      (live_q[gi*2*BCD_W +: 2*BCD_W]),
            .value_next_o (live_d[gi*2*BCD_W +: 2*BCD_W]),
            .carry_out_o  (cout),
            .borrow_out_o (bout)
        );
    end

    assign all_max  = g_field[NUM_FIELDS-1].cout;
    assign all_zero = g_field[NUM_FIELDS-1].bout;

    assign expired_d = count_en & (dir ? all_zero : all_max);

    always_comb begin
        state_d = state_q;
        if (adj) begin
            state_d = ST_ADJUST;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (pause_edge)
                        state_d = ST_PAUSED;
                    else if (expired_d && (dir || (WRAP == 0)))
                        state_d = ST_DONE;
                end
                ST_PAUSED: if (pause_edge) state_d = ST_RUN;
                ST_ADJUST: if (adj_fall)   state_d = ST_PAUSED;
                ST_DONE:   if (pause_edge) state_d = ST_PAUSED;
                default:   state_d = ST_RUN;
            endcase
        end
    end

    // Snapshot takes live_q, i.e. the value before any same-cycle tick.
    always_comb begin
        lap_d  = lap_q;
        snap_d = snap_q;
        if (adj) begin
            lap_d = 1'b0;
        end else if (lap_edge) begin
            if (lap_q) begin
                lap_d = 1'b0;
            end else if (state_q == ST_RUN || state_q == ST_PAUSED) begin
                lap_d  = 1'b1;
                snap_d = live_q;
            end
        end
    end

    assign digits_d = lap_d ? snap_d : live_d;

    always_comb begin
        blank_d = '0;
        if (state_d == ST_ADJUST && !tick_blink) begin
            for (int f = 0; f < NUM_FIELDS; f++) begin
                if (sel != SEL_W'(f))
                    blank_d[2*f +: 2] = 2'b11;
            end
        end
    end

    always_ff @(posedge MegaClk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            pause_prev_q <= 1'b0;
            lap_prev_q   <= 1'b0;
            adj_prev_q   <= 1'b0;
            lap_q        <= 1'b0;
            expired_q    <= 1'b0;
            snap_q       <= '0;
            digits_q     <= '0;
            blank_q      <= '0;
        end else begin
            state_q      <= state_d;
            pause_prev_q <= pause_btn;
            lap_prev_q   <= lap_btn;
            adj_prev_q   <= adj;
            lap_q        <= lap_d;
            expired_q    <= expired_d;
            snap_q       <= snap_d;
            digits_q     <= digits_d;
            blank_q      <= blank_d;
        end
    end

    assign digits_o     = digits_q;
    assign blank_o      = blank_q;
    assign running_o    = (state_q == ST_RUN);
    assign lap_active_o = lap_q;
    assign expired_o    = expired_q;

endmodule

// File: tb/tb_lap_timer.sv
module tb_lap_timer;

    logic        MegaClk = 1'b0;
    logic        reset = 1'b1;
    logic        tick_1hz = 1'b0, tick_adj = 1'b0, tick_blink = 1'b1;
    logic        pause_btn = 1'b0, lap_btn = 1'b0, adj = 1'b0, dir = 1'b0;
    logic [0:0]  sel = 1'b0;

    logic [15:0] digits_w, digits_s;
    logic [3:0]  blank_w, blank_s;
    logic        run_w, run_s, lap_w, lap_s, exp_w, exp_s;

    int n_checks = 0;
    int n_errors = 0;

    always #5 MegaClk = ~MegaClk;

    lap_timer #(.NUM_FIELDS(2), .WRAP(1)) u_wrap (
        .MegaClk(MegaClk), .reset(reset), .tick_1hz(tick_1hz), .tick_adj(tick_adj),
        .tick_blink(tick_blink), .pause_btn(pause_btn), .lap_btn(lap_btn), .adj(adj),
        .sel(sel), .dir(dir), .digits_o(digits_w), .blank_o(blank_w),
        .running_o(run_w), .lap_active_o(lap_w), .expired_o(exp_w)
    );

    lap_timer #(.NUM_FIELDS(2), .WRAP(0)) u_sat (
        .MegaClk(MegaClk), .reset(reset), .tick_1hz(tick_1hz), .tick_adj(tick_adj),
        .tick_blink(tick_blink), .pause_btn(pause_btn), .lap_btn(lap_btn), .adj(adj),
        .sel(sel), .dir(dir), .digits_o(digits_s), .blank_o(blank_s),
        .running_o(run_s), .lap_active_o(lap_s), .expired_o(exp_s)
    );

    task automatic cyc();
        @(posedge MegaClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        tick_1hz = 1'b1;
        repeat (n) cyc();
        tick_1hz = 1'b0;
    endtask

    task automatic adj_ticks(input int n);
        tick_adj = 1'b1;
        repeat (n) cyc();
        tick_adj = 1'b0;
    endtask

    task automatic pause_press();
        pause_btn = 1'b1;
        cyc();
        pause_btn = 1'b0;
        cyc();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        cyc();
        reset = 1'b1;
        cyc();
    endtask

    initial begin
        // reset state
        #3 reset = 1'b0;
        #1;
        chk("rst_digits", digits_w, 16'h0000);
        chk("rst_blank", blank_w, 4'b0000);
        chk("rst_running", run_w, 1'b1);
        chk("rst_lap", lap_w, 1'b0);
        chk("rst_expired", exp_w, 1'b0);
        cyc();
        reset = 1'b1;
        cyc();

        // first tick counts, then up to 01:00
        ticks(1);
        chk("first_tick", digits_w, 16'h0001);
        ticks(59);
        chk("up_60", digits_w, 16'h0100);

        // adjust both timers to 99:59
        adj = 1'b1;
        cyc();
        chk("adj_running", run_w, 1'b0);
        sel = 1'b1; dir = 1'b1;
        adj_ticks(2);
        sel = 1'b0;
        adj_ticks(1);
        chk("adj_9959", digits_w, 16'h9959);
        adj = 1'b0;
        cyc();
        chk("adj_exit_paused", run_w, 1'b0);
        pause_press();
        chk("resume_running", run_w, 1'b1);

        // terminal up count
        dir = 1'b0;
        ticks(1);
        chk("wrap_digits", digits_w, 16'h0000);
        chk("wrap_expired", exp_w, 1'b1);
        chk("wrap_running", run_w, 1'b1);
        chk("sat_digits", digits_s, 16'h9959);
        chk("sat_expired", exp_s, 1'b1);
        chk("sat_running", run_s, 1'b0);
        cyc();
        chk("wrap_exp_pulse", exp_w, 1'b0);
        chk("sat_exp_pulse", exp_s, 1'b0);
        ticks(1);
        chk("wrap_after", digits_w, 16'h0001);
        chk("sat_done_hold", digits_s, 16'h9959);
        chk("sat_done_noexp", exp_s, 1'b0);
        pause_press();
        chk("sat_done_to_paused", run_s, 1'b0);
        chk("wrap_to_paused", run_w, 1'b0);
        pause_press();
        chk("sat_paused_to_run", run_s, 1'b1);

        // down count
        do_reset();
        ticks(60);
        chk("down_start", digits_w, 16'h0100);
        dir = 1'b1;
        ticks(1);
        chk("down_borrow", digits_w, 16'h0059);
        ticks(59);
        chk("down_zero", digits_w, 16'h0000);
        chk("down_zero_noexp", exp_w, 1'b0);
        ticks(1);
        chk("down_term_digits", digits_w, 16'h0000);
        chk("down_term_exp", exp_w, 1'b1);
        chk("down_term_done", run_w, 1'b0);
        chk("down_term_sat_done", run_s, 1'b0);
        dir = 1'b0;

        // lap
        do_reset();
        ticks(12);
        lap_btn = 1'b1;
        cyc();
        lap_btn = 1'b0;
        chk("lap_set", lap_w, 1'b1);
        ticks(5);
        chk("lap_frozen", digits_w, 16'h0012);
        chk("lap_still", lap_w, 1'b1);
        lap_btn = 1'b1;
        cyc();
        lap_btn = 1'b0;
        chk("lap_release", digits_w, 16'h0017);
        chk("lap_clear", lap_w, 1'b0);
        cyc();
        lap_btn = 1'b1; tick_1hz = 1'b1;
        cyc();
        lap_btn = 1'b0; tick_1hz = 1'b0;
        chk("lap_tick_snap", digits_w, 16'h0017);
        cyc();
        lap_btn = 1'b1;
        cyc();
        lap_btn = 1'b0;
        chk("lap_tick_live", digits_w, 16'h0018);

        // adjust at 98:30
        do_reset();
        adj = 1'b1;
        cyc();
        sel = 1'b1; dir = 1'b1;
        adj_ticks(2);
        sel = 1'b0; dir = 1'b0;
        adj_ticks(30);
        chk("adj_9830", digits_w, 16'h9830);
        sel = 1'b1;
        adj_ticks(3);
        chk("adj_nocarry", digits_w, 16'h0130);
        tick_blink = 1'b0;
        cyc();
        chk("blank_sel1", blank_w, 4'b0011);
        sel = 1'b0;
        cyc();
        chk("blank_sel0", blank_w, 4'b1100);
        tick_blink = 1'b1;
        cyc();
        chk("blank_phase1", blank_w, 4'b0000);
        tick_blink = 1'b0; pause_btn = 1'b1;
        cyc();
        pause_btn = 1'b0;
        chk("pause_ignored_adj", blank_w, 4'b1100);
        tick_blink = 1'b1;
        adj = 1'b0;
        cyc();
        chk("adj_fall_paused", run_w, 1'b0);
        chk("adj_fall_blank", blank_w, 4'b0000);
        ticks(1);
        chk("paused_no_count", digits_w, 16'h0130);
        pause_press();
        chk("paused_resume", run_w, 1'b1);

        // same-cycle tick and pause
        do_reset();
        ticks(5);
        chk("tp_start", digits_w, 16'h0005);
        tick_1hz = 1'b1; pause_btn = 1'b1;
        cyc();
        tick_1hz = 1'b0; pause_btn = 1'b0;
        chk("tp_counted", digits_w, 16'h0006);
        chk("tp_paused", run_w, 1'b0);
        ticks(1);
        chk("tp_hold", digits_w, 16'h0006);

        // adj rising edge beats a tick
        pause_press();
        adj = 1'b1; tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        chk("adj_beats_tick", digits_w, 16'h0006);
        chk("adj_beats_state", run_w, 1'b0);

        // reset mid-adjust
        sel = 1'b1; tick_blink = 1'b0;
        cyc();
        chk("pre_rst_blank", blank_w, 4'b0011);
        reset = 1'b0;
        #1;
        chk("mid_rst_digits", digits_w, 16'h0000);
        chk("mid_rst_blank", blank_w, 4'b0000);
        chk("mid_rst_running", run_w, 1'b1);
        adj = 1'b0; tick_blink = 1'b1;
        cyc();
        reset = 1'b1;
        cyc();
        ticks(1);
        chk("post_rst_tick", digits_w, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
